// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, parity codes and parity helper
// Purpose: definitions shared by the transmit scheduler and the transmitter.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_ODD      = 2'b01;
  localparam logic [1:0] PAR_EVEN     = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  // Bit 7 only contributes in 8-bit mode; odd parity is the inverted XOR.
  function automatic logic calc_parity(input logic [7:0] data,
                                       input logic       data_length,
                                       input logic [1:0] parity_type);
    logic w_p;
    w_p = (^data[6:0]) ^ (data_length & data[7]);
    case (parity_type)
      PAR_ODD:                return ~w_p;
      PAR_EVEN:               return w_p;
      PAR_NONE, PAR_NONE_ALT: return 1'b0;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter
// Purpose: picks one requester; on contention the one not served last wins.
// Ports: req  - request vector
//        last - index of the requester served most recently
//        win  - one-hot winner, zero when no request
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - arbitrates two requesters onto one UART transmitter
// Purpose: latches the winning payload and parity, hands it to the transmitter
//          with send, watches tx_active/tx_done and acks the owner.
// Ports: baud_clk/arst_n       - clock, async active-low reset
//        req, data0, data1     - requester handshake and payloads
//        data_length, parity_type - frame format, sampled at latch time
//        tx_active, tx_done    - transmitter status
//        send, data_out, parity_out - transmitter command
//        grant, ack, err, busy - status back to requesters
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       baud_clk,
  input  logic       arst_n,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       data_length,
  input  logic [1:0] parity_type,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic       send,
  output logic [7:0] data_out,
  output logic       parity_out,
  output logic [1:0] grant,
  output logic [1:0] ack,
  output logic       err,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_grant;
  logic [7:0]      r_data;
  logic            r_par;
  logic            r_last;
  logic            r_err;
  logic [1:0]      w_win;
  logic [7:0]      w_sel_data;
  logic            w_timeout;

  rr_arb2 u_arb (
    .req  (req),
    .last (r_last),
    .win  (w_win)
  );

  assign w_sel_data = w_win[1] ? data1 : data0;

  // Counter value TIMEOUT-1 before the edge means this edge is the TIMEOUT-th
  // SEND cycle without tx_active.
  assign w_timeout = (r_state == ST_SEND) && !tx_active &&
                     (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge baud_clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (|req) w_next = ST_SEND;
      ST_SEND: begin
        if (tx_active)      w_next = ST_ACTIVE;
        else if (w_timeout) w_next = ST_IDLE;
      end
      ST_ACTIVE: if (!tx_active && tx_done) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    send = (r_state == ST_SEND);
    busy = (r_state != ST_IDLE);
    ack  = (r_state == ST_DONE) ? r_grant : 2'b00;
  end

  assign grant      = r_grant;
  assign data_out   = r_data;
  assign parity_out = r_par;
  assign err        = r_err;

  // r_last resets to 1 so that requester 0 wins the first contention.
  always_ff @(posedge baud_clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt   <= '0;
      r_grant <= 2'b00;
      r_data  <= 8'h00;
      r_par   <= 1'b0;
      r_last  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_timeout;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (|req) begin
            r_grant <= w_win;
            r_data  <= w_sel_data;
            r_par   <= calc_parity(w_sel_data, data_length, parity_type);
          end
        end
        ST_SEND: begin
          if (tx_active) begin
            r_cnt <= '0;
          end else if (w_timeout) begin
            r_cnt   <= '0;
            r_grant <= 2'b00;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          r_last  <= r_grant[1];
          r_grant <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

  logic       baud_clk;
  logic       arst_n;
  logic [1:0] req;
  logic [7:0] data0, data1;
  logic       data_length;
  logic [1:0] parity_type;
  logic       tx_active, tx_done;
  logic       send;
  logic [7:0] data_out;
  logic       parity_out;
  logic [1:0] grant, ack;
  logic       err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_scheduler #(.TIMEOUT(15)) dut (
    .baud_clk    (baud_clk),
    .arst_n      (arst_n),
    .req         (req),
    .data0       (data0),
    .data1       (data1),
    .data_length (data_length),
    .parity_type (parity_type),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .send        (send),
    .data_out    (data_out),
    .parity_out  (parity_out),
    .grant       (grant),
    .ack         (ack),
    .err         (err),
    .busy        (busy)
  );

  initial begin
    baud_clk = 1'b0;
    forever #5 baud_clk = ~baud_clk;
  end

  typedef struct {
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       len;
    logic [1:0] pt;
    logic [1:0] g;
    logic [7:0] dout;
    logic       par;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_send"},  {31'd0, send},       32'd0);
    chk({tag, "_dout"},  {24'd0, data_out},   32'd0);
    chk({tag, "_par"},   {31'd0, parity_out}, 32'd0);
    chk({tag, "_grant"}, {30'd0, grant},      32'd0);
    chk({tag, "_ack"},   {30'd0, ack},        32'd0);
    chk({tag, "_err"},   {31'd0, err},        32'd0);
    chk({tag, "_busy"},  {31'd0, busy},       32'd0);
  endtask

  task automatic reset_dut();
    req = 2'b00; tx_active = 1'b0; tx_done = 1'b1;
    arst_n = 1'b0;
    tick();
    tick();
    arst_n = 1'b1;
  endtask

  // Transmitter accepts, runs one busy cycle, then finishes; ack expected.
  task automatic finish_frame(input string tag, input logic [1:0] exp_ack);
    tx_active = 1'b1; tx_done = 1'b0;
    tick();
    chk({tag, "_send_drop"}, {31'd0, send}, 32'd0);
    chk({tag, "_busy_act"},  {31'd0, busy}, 32'd1);
    tx_active = 1'b0; tx_done = 1'b1;
    tick();
    chk({tag, "_ack"}, {30'd0, ack}, {30'd0, exp_ack});
  endtask

  initial begin
    vecs[0] = '{2'b01, 8'h75, 8'h00, 1'b1, 2'b10, 2'b01, 8'h75, 1'b1};
    vecs[1] = '{2'b10, 8'h00, 8'hF5, 1'b0, 2'b01, 2'b10, 8'hF5, 1'b0};
    vecs[2] = '{2'b11, 8'hA5, 8'h3C, 1'b1, 2'b01, 2'b01, 8'hA5, 1'b1};
    vecs[3] = '{2'b11, 8'h00, 8'h80, 1'b1, 2'b10, 2'b10, 8'h80, 1'b1};
    vecs[4] = '{2'b10, 8'h00, 8'h80, 1'b0, 2'b01, 2'b10, 8'h80, 1'b1};
    vecs[5] = '{2'b01, 8'hFF, 8'h00, 1'b1, 2'b11, 2'b01, 8'hFF, 1'b0};
    vecs[6] = '{2'b01, 8'hFF, 8'h00, 1'b1, 2'b10, 2'b01, 8'hFF, 1'b0};
    vecs[7] = '{2'b01, 8'hFF, 8'h00, 1'b0, 2'b10, 2'b01, 8'hFF, 1'b1};
    vecs[8] = '{2'b11, 8'h12, 8'h34, 1'b1, 2'b00, 2'b10, 8'h34, 1'b0};

    req = 2'b00; data0 = 8'h00; data1 = 8'h00; data_length = 1'b1;
    parity_type = 2'b00; tx_active = 1'b0; tx_done = 1'b1;
    arst_n = 1'b0;
    #3;
    chk_all_zero("reset");
    tick();
    arst_n = 1'b1;
    tick();
    chk_all_zero("idle");

    // Table-driven frames; round-robin history carries across vectors.
    for (int i = 0; i < 9; i++) begin
      req = vecs[i].req; data0 = vecs[i].d0; data1 = vecs[i].d1;
      data_length = vecs[i].len; parity_type = vecs[i].pt;
      tick();
      chk($sformatf("v%0d_send", i),  {31'd0, send},       32'd1);
      chk($sformatf("v%0d_grant", i), {30'd0, grant},      {30'd0, vecs[i].g});
      chk($sformatf("v%0d_dout", i),  {24'd0, data_out},   {24'd0, vecs[i].dout});
      chk($sformatf("v%0d_par", i),   {31'd0, parity_out}, {31'd0, vecs[i].par});
      // Inputs change after latch; outputs must not follow.
      data0 = ~vecs[i].d0; data1 = ~vecs[i].d1;
      data_length = ~vecs[i].len; parity_type = ~vecs[i].pt;
      finish_frame($sformatf("v%0d", i), vecs[i].g);
      chk($sformatf("v%0d_dout_hold", i), {24'd0, data_out},   {24'd0, vecs[i].dout});
      chk($sformatf("v%0d_par_hold", i),  {31'd0, parity_out}, {31'd0, vecs[i].par});
      req = 2'b00;
      tick();
      chk($sformatf("v%0d_ack_clr", i),   {30'd0, ack},   32'd0);
      chk($sformatf("v%0d_grant_clr", i), {30'd0, grant}, 32'd0);
      chk($sformatf("v%0d_idle", i),      {31'd0, busy},  32'd0);
    end

    // Both requesters held: 0 first, then 1; no regrant in the ack cycle.
    reset_dut();
    req = 2'b11; data0 = 8'h11; data1 = 8'h22; parity_type = 2'b00;
    tick();
    chk("rr_g0", {30'd0, grant}, 32'd1);
    finish_frame("rr_f0", 2'b01);
    req = 2'b10;
    tick();
    chk("rr_gap_grant", {30'd0, grant}, 32'd0);
    chk("rr_gap_send",  {31'd0, send},  32'd0);
    tick();
    chk("rr_g1",    {30'd0, grant},    32'd2);
    chk("rr_send1", {31'd0, send},     32'd1);
    chk("rr_d1",    {24'd0, data_out}, 32'h22);
    tx_active = 1'b1; tx_done = 1'b0;
    tick();
    data1 = 8'h99; req = 2'b11;
    tick();
    req = 2'b10; tx_active = 1'b0; tx_done = 1'b1;
    tick();
    chk("rr_ack1",   {30'd0, ack},      32'd2);
    chk("rr_d1hold", {24'd0, data_out}, 32'h22);
    req = 2'b00;
    tick();
    tick();
    chk("short_req_send",  {31'd0, send},  32'd0);
    chk("short_req_grant", {30'd0, grant}, 32'd0);

    // Transmitter never responds: abort after TIMEOUT cycles of send.
    reset_dut();
    req = 2'b01; data0 = 8'h55;
    tick();
    chk("to_send", {31'd0, send}, 32'd1);
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk($sformatf("to_wait%0d", k), {30'd0, err, send}, 32'd1);
    end
    tick();
    chk("to_err",   {31'd0, err},   32'd1);
    chk("to_send0", {31'd0, send},  32'd0);
    chk("to_grant", {30'd0, grant}, 32'd0);
    chk("to_ack",   {30'd0, ack},   32'd0);
    chk("to_busy",  {31'd0, busy},  32'd0);
    req = 2'b00;
    tick();
    chk("to_err_pulse", {31'd0, err},  32'd0);
    chk("to_busy_next", {31'd0, busy}, 32'd0);
    chk("to_ack_next",  {30'd0, ack},  32'd0);
    req = 2'b11;
    tick();
    chk("to_ptr_kept", {30'd0, grant}, 32'd1);
    finish_frame("to_f", 2'b01);
    req = 2'b00;
    tick();

    // Reset in the middle of a frame owned by requester 1.
    req = 2'b10; data1 = 8'hC3;
    tick();
    chk("mr_grant", {30'd0, grant}, 32'd2);
    tx_active = 1'b1; tx_done = 1'b0;
    tick();
    chk("mr_busy", {31'd0, busy}, 32'd1);
    #2;
    arst_n = 1'b0;
    #1;
    chk_all_zero("mr_async");
    req = 2'b00; tx_active = 1'b0; tx_done = 1'b1;
    tick();
    chk("mr_ack_in_rst", {30'd0, ack}, 32'd0);
    arst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mr_ack_after%0d", k), {30'd0, ack, busy}, 32'd0);
    end
    req = 2'b11;
    tick();
    chk("mr_ptr_reset", {30'd0, grant}, 32'd1);
    finish_frame("mr_f", 2'b01);
    req = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
